// File: rtl/sq_freq_meter.sv
// Gated frequency meter for a 1-bit square wave.
// Counts synchronised rising edges of sig_in over a 2^GATE_LOG2-clock gate and
// reports the count both raw and scaled into an NCO phase increment.
//
// Handshake: start is a single-cycle request that is only honoured in IDLE;
// valid is a one-cycle pulse with no backpressure, and edge_count /
// phase_inc_est hold their value until the next result overwrites them.
module sq_freq_meter #(
    parameter int WIDTH       = 64,
    parameter int GATE_LOG2   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sig_in,
    input  logic                 start,
    input  logic                 continuous,
    output logic                 busy,
    output logic                 valid,
    output logic [GATE_LOG2-1:0] edge_count,
    output logic [WIDTH-1:0]     phase_inc_est,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GATE   = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_clear;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_s;
    logic                   w_rise;

    // Both counters fit in GATE_LOG2 bits: a rising edge needs at least two
    // cycles, so the edge count never exceeds 2^(GATE_LOG2-1).
    logic [GATE_LOG2-1:0]   r_gate_cnt;
    logic [GATE_LOG2-1:0]   r_edge_acc;
    logic                   w_gate_last;

    logic                   r_valid;
    logic [GATE_LOG2-1:0]   r_edge_count;
    logic [WIDTH-1:0]       r_phase;
    logic [WIDTH-1:0]       w_phase_nxt;

    assign w_s         = r_sync[SYNC_STAGES-1];
    assign w_rise      = w_s & ~r_prev;
    assign w_gate_last = (r_gate_cnt == {GATE_LOG2{1'b1}});
    // Shifting left by WIDTH-GATE_LOG2 is just appending zeros.
    assign w_phase_nxt = {r_edge_acc, {(WIDTH-GATE_LOG2){1'b0}}};

    // Input synchroniser plus previous-sample flop, running in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_prev <= w_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; w_clear marks the edge on which a new gate begins.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_GATE;
                    w_clear     = 1'b1;
                end
            end
            ST_GATE: begin
                if (w_gate_last) begin
                    w_state_nxt = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                if (continuous) begin
                    w_state_nxt = ST_GATE;
                    w_clear     = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Gate and edge counters; edges in the UPDATE cycle are deliberately dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gate_cnt <= '0;
            r_edge_acc <= '0;
        end else if (w_clear) begin
            r_gate_cnt <= '0;
            r_edge_acc <= '0;
        end else if (r_state == ST_GATE) begin
            r_gate_cnt <= r_gate_cnt + 1'b1;
            if (w_rise) begin
                r_edge_acc <= r_edge_acc + 1'b1;
            end
        end
    end

    // Result registers, loaded and flagged on the edge leaving UPDATE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_edge_count <= '0;
            r_phase      <= '0;
        end else begin
            r_valid <= (r_state == ST_UPDATE);
            if (r_state == ST_UPDATE) begin
                r_edge_count <= r_edge_acc;
                r_phase      <= w_phase_nxt;
            end
        end
    end

    assign busy          = (r_state != ST_IDLE);
    assign valid         = r_valid;
    assign edge_count    = r_edge_count;
    assign phase_inc_est = r_phase;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_sq_freq_meter.sv
// Testbench for sq_freq_meter (WIDTH=64, GATE_LOG2=8, SYNC_STAGES=2).
// Stimulus pushes the start edge of every expected measurement into exp_q;
// the monitor pops one entry per valid pulse and compares the result against
// a rising-edge count taken directly from the recorded input waveform.
module tb_sq_freq_meter;

    localparam int WIDTH     = 64;
    localparam int GATE_LOG2 = 8;
    localparam int GATE_LEN  = 1 << GATE_LOG2;
    localparam int HIST      = 16384;
    localparam logic [63:0] NCO_INC = 64'd1 << 58;

    // ---------------- clock / reset ----------------
    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 sig_in;
    logic                 start;
    logic                 continuous;
    logic                 busy;
    logic                 valid;
    logic [GATE_LOG2-1:0] edge_count;
    logic [WIDTH-1:0]     phase_inc_est;
    logic [1:0]           dbg_state;

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    sq_freq_meter #(
        .WIDTH(WIDTH), .GATE_LOG2(GATE_LOG2), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start),
        .continuous(continuous), .busy(busy), .valid(valid),
        .edge_count(edge_count), .phase_inc_est(phase_inc_est),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- input waveform generator ----------------
    // sig_hist[c] is the value sig_in holds between posedge c and posedge c+1.
    int          sig_mode = 0;   // 0 const0, 1 const1, 2 periodic, 3 nco, 4 random bits
    int unsigned per_len = 16, per_high = 8, per_phase = 0;
    logic [63:0] nco_acc = '0;
    bit          sig_hist[HIST];

    always @(negedge clk) begin : gen_sig
        logic v;
        case (sig_mode)
            0: v = 1'b0;
            1: v = 1'b1;
            2: v = ((cyc + per_phase) % per_len) < per_high;
            3: begin
                nco_acc = nco_acc + NCO_INC;
                v = nco_acc[63];
            end
            default: v = 1'($urandom_range(0, 1));
        endcase
        sig_in = v;
        if (cyc < HIST) sig_hist[cyc] = v;
    end

    // ---------------- reference model ----------------
    // A measurement whose start is sampled at edge k gates the 256 cycles that
    // follow edge k. The synchroniser shows the meter the input two cycles late,
    // so the gate sees input samples k-2 .. k+253; count their 0->1 transitions.
    function automatic int unsigned model_count(input int unsigned k);
        int unsigned cnt = 0;
        for (int unsigned n = k - 2; n <= k + GATE_LEN - 3; n++)
            if (sig_hist[n] && !sig_hist[n-1]) cnt++;
        return cnt;
    endfunction

    function automatic logic [63:0] model_phase(input int unsigned cnt);
        return 64'(cnt) * (64'd1 << (WIDTH - GATE_LOG2));
    endfunction

    // ---------------- monitor ----------------
    logic prev_valid = 1'b0;
    always @(negedge clk) begin : monitor
        int unsigned k;
        int unsigned cnt;
        if (rst_n && valid) begin
            check("valid_pulse_width", 64'(prev_valid), 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 64'd1, 64'd0);
            end else begin
                k   = exp_q.pop_front();
                cnt = model_count(k);
                // valid is first seen by the posedge after this negedge
                check("valid_latency", 64'(cyc + 1 - k), 64'(GATE_LEN + 2));
                check("edge_count", 64'(edge_count), 64'(cnt));
                check("phase_inc_est", phase_inc_est, model_phase(cnt));
            end
        end
        prev_valid = rst_n & valid;
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int unsigned target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic do_start(output int unsigned k);
        start = 1'b1;
        k = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic measure(output int unsigned k);
        do_start(k);
        exp_q.push_back(32'(k));
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 1500 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) done = 1'b1;
        end
        check({name, "_completes"}, 64'(done), 64'd1);
        exp_q.delete();
    endtask

    task automatic set_periodic(input int unsigned len, input int unsigned high);
        per_len   = len;
        per_high  = high;
        per_phase = $urandom_range(0, len - 1);
        sig_mode  = 2;
    endtask

    task automatic check_cleared(input string name);
        check({name, "_busy"},  64'(busy), 64'd0);
        check({name, "_valid"}, 64'(valid), 64'd0);
        check({name, "_count"}, 64'(edge_count), 64'd0);
        check({name, "_phase"}, phase_inc_est, 64'd0);
    endtask

    // Asynchronous reset asserted between clock edges, checked before the next edge.
    task automatic async_reset(input string name);
        #2;
        rst_n = 1'b0;
        #1;
        check_cleared(name);
        check({name, "_state"}, 64'(dbg_state), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- main stimulus ----------------
    initial begin : stim
        int unsigned k;
        rst_n = 1'b0;
        start = 1'b0;
        continuous = 1'b0;
        sig_mode = 0;
        wait_cycles(3);
        check_cleared("reset");
        check("reset_state", 64'(dbg_state), 64'd0);
        rst_n = 1'b1;
        wait_cycles(10);

        // Period-16, 50% duty: 16 edges, phase 2^60.
        set_periodic(16, 8);
        wait_cycles(8);
        measure(k);
        wait_idle("p16");
        check("p16_count", 64'(edge_count), 64'd16);
        check("p16_phase", phase_inc_est, 64'h1000_0000_0000_0000);

        // Outputs hold non-zero values here, so the reset must visibly clear them.
        async_reset("async_reset");
        wait_cycles(10);

        // NCO loop-back with phase increment 2^58 (period 64).
        sig_mode = 3;
        wait_cycles(8);
        measure(k);
        wait_idle("nco");
        check("nco_count", 64'(edge_count), 64'd4);
        check("nco_phase", phase_inc_est, NCO_INC);

        // Toggling every clock: Nyquist limit.
        set_periodic(2, 1);
        wait_cycles(8);
        measure(k);
        wait_idle("toggle");
        check("toggle_count", 64'(edge_count), 64'd128);
        check("toggle_phase", phase_inc_est, 64'h8000_0000_0000_0000);

        // Constant high, then constant low.
        sig_mode = 1;
        wait_cycles(8);
        measure(k);
        wait_idle("const1");
        check("const1_count", 64'(edge_count), 64'd0);
        sig_mode = 0;
        wait_cycles(8);
        measure(k);
        wait_idle("const0");
        check("const0_phase", phase_inc_est, 64'd0);

        // continuous alone must not start a measurement.
        continuous = 1'b1;
        wait_cycles(20);
        check("continuous_alone_busy", 64'(busy), 64'd0);
        continuous = 1'b0;

        // Randomised single measurements, some with ignored start pulses.
        for (int r = 0; r < 8; r++) begin
            if ($urandom_range(0, 3) == 3) begin
                sig_mode = 4;
            end else begin
                per_len = $urandom_range(2, 40);
                set_periodic(per_len, $urandom_range(1, per_len - 1));
            end
            wait_cycles(8);
            measure(k);
            if ($urandom_range(0, 1) == 1) begin
                wait_cycles($urandom_range(5, 200));
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            wait_idle("random");
        end

        // Continuous mode, period 32: results every 257 clocks, restarts ignored,
        // continuous dropped mid-gate gives exactly one more result.
        set_periodic(32, 16);
        wait_cycles(8);
        continuous = 1'b1;
        do_start(k);
        exp_q.push_back(32'(k));
        exp_q.push_back(32'(k + GATE_LEN + 1));
        exp_q.push_back(32'(k + 2 * (GATE_LEN + 1)));
        wait_until(k + 50);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(k + 300);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(k + 2 * (GATE_LEN + 1) + 100);
        continuous = 1'b0;
        wait_idle("continuous");
        check("cont_last_count", 64'(edge_count), 64'd8);
        wait_cycles(300);
        check("cont_idle_after_drop", 64'(busy), 64'd0);

        // Reset mid-gate: no result, back to idle.
        set_periodic(10, 5);
        wait_cycles(8);
        do_start(k);
        wait_until(k + 100);
        check("mid_gate_busy", 64'(busy), 64'd1);
        async_reset("reset_mid_gate");
        wait_cycles(300);
        check("mid_gate_idle", 64'(busy), 64'd0);

        // Reset during the UPDATE cycle: result never appears.
        wait_cycles(8);
        measure(k);
        exp_q.delete();
        wait_until(k + GATE_LEN);
        check("update_state", 64'(dbg_state), 64'd2);
        async_reset("reset_in_update");
        wait_cycles(300);
        check("update_reset_idle", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
